asm_state_reg_p: RTL and testbench

Parametrised ASM state register for loop-control sequencing: per-bit set/reset pulse inputs drive a WIDTH-bit binary state code, which is decoded to a one-hot bus of 2^WIDTH state lines. It is the clocked successor to the latch-based 3-bit state block. It replaces fixed delay cells with a registered input stage and defines set/reset conflict resolution. New features are a hold mode, a state-change strobe, a saturating dwell counter and a dwell timeout flag. It sits in the loop control path between the transition logic and the per-state enables.

---
 rtl/asm_state_reg_p_if.sv | 17 +
 rtl/asm_state_reg_p.sv | 55 +++++
 tb/tb_asm_state_reg_p.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/asm_state_reg_p_if.sv
// asm_state_reg_p_if: request/response bundle between transition logic and the state register
interface asm_state_reg_p_if #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 8
);
  logic [WIDTH-1:0]      set;
  logic [WIDTH-1:0]      rst;
  logic                  hold;
  logic [WIDTH-1:0]      state_code;
  logic [2**WIDTH-1:0]   state;
  logic                  changed;
  logic                  conflict;
  logic [DWELL_W-1:0]    dwell;
  logic                  timeout;
  modport master (output set, rst, hold, input state_code, state, changed, conflict, dwell, timeout);
  modport slave  (input set, rst, hold, output state_code, state, changed, conflict, dwell, timeout);
endinterface

// File: rtl/asm_state_reg_p.sv
// asm_state_reg_p: registered set/reset state code with one-hot decode, change strobe and dwell timeout
module asm_state_reg_p #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 8,
  parameter int TIMEOUT = 200
) (
  input logic              clk,
  input logic              porb,
  asm_state_reg_p_if.slave bus
);
  localparam int N = 2**WIDTH;
  localparam logic [DWELL_W-1:0] DMAX = '1;
  localparam logic [DWELL_W-1:0] TMO  = DWELL_W'(TIMEOUT);
  logic [WIDTH-1:0]   set_q, rst_q, code_q, code_d;
  logic               hold_q, chg;
  logic [N-1:0]       state_q;
  logic               changed_q, conflict_q, timeout_q, timeout_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  // reset wins over set on each bit; the registered hold freezes the whole code
  always_comb begin
    code_d    = hold_q ? code_q : (code_q | set_q) & ~rst_q;
    chg       = code_d != code_q;
    dwell_d   = chg ? '0 : dwell_q == DMAX ? dwell_q : dwell_q + DWELL_W'(1);
    timeout_d = !chg && dwell_d >= TMO;
  end
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      set_q      <= '0;
      rst_q      <= '0;
      hold_q     <= 1'b0;
      code_q     <= '0;
      state_q    <= N'(1);
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
      dwell_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      set_q      <= bus.set;
      rst_q      <= bus.rst;
      hold_q     <= bus.hold;
      code_q     <= code_d;
      state_q    <= N'(1) << code_d;
      changed_q  <= chg;
      conflict_q <= !hold_q && |(set_q & rst_q);
      dwell_q    <= dwell_d;
      timeout_q  <= timeout_d;
    end
  end
  assign bus.state_code = code_q;
  assign bus.state      = state_q;
  assign bus.changed    = changed_q;
  assign bus.conflict   = conflict_q;
  assign bus.dwell      = dwell_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_asm_state_reg_p.sv
// tb_asm_state_reg_p: directed stimulus with cycle-tagged expectations checked by a negedge monitor
module tb_asm_state_reg_p;
  logic clk, porb;
  int cyc = 0, now = 0, checks = 0, errors = 0;
  typedef struct {
    int          cyc;
    bit          w4;
    string       tag;
    logic [3:0]  code;
    logic [15:0] state;
    logic        chg, cf;
    logic [7:0]  dw;
    logic        to;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  asm_state_reg_p_if #(.WIDTH(3), .DWELL_W(8)) i3 ();
  asm_state_reg_p_if #(.WIDTH(4), .DWELL_W(8)) i4 ();
  asm_state_reg_p #(.WIDTH(3), .DWELL_W(8), .TIMEOUT(200)) d3 (.clk(clk), .porb(porb), .bus(i3));
  asm_state_reg_p #(.WIDTH(4), .DWELL_W(8), .TIMEOUT(200)) d4 (.clk(clk), .porb(porb), .bus(i4));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d got none want check", cur.tag, cur.cyc);
      end else if (cur.w4) begin
        chk({cur.tag, " code"}, 32'(i4.state_code), 32'(cur.code));
        chk({cur.tag, " state"}, 32'(i4.state), 32'(cur.state));
        chk({cur.tag, " onehot"}, 32'($onehot(i4.state)), 32'(1));
        chk({cur.tag, " changed"}, 32'(i4.changed), 32'(cur.chg));
      end else begin
        chk({cur.tag, " code"}, 32'(i3.state_code), 32'(cur.code));
        chk({cur.tag, " state"}, 32'(i3.state), 32'(cur.state));
        chk({cur.tag, " changed"}, 32'(i3.changed), 32'(cur.chg));
        chk({cur.tag, " conflict"}, 32'(i3.conflict), 32'(cur.cf));
        chk({cur.tag, " dwell"}, 32'(i3.dwell), 32'(cur.dw));
        chk({cur.tag, " timeout"}, 32'(i3.timeout), 32'(cur.to));
      end
    end
  end
  task automatic e3(int at, string tag, logic [2:0] code, logic [7:0] st, logic chg, logic cf, logic [7:0] dw, logic to);
    exp_t x;
    x.cyc = at; x.w4 = 1'b0; x.tag = tag; x.code = {1'b0, code}; x.state = {8'h00, st};
    x.chg = chg; x.cf = cf; x.dw = dw; x.to = to;
    sb.push_back(x);
  endtask
  task automatic e4(int at, string tag, logic [3:0] code, logic [15:0] st, logic chg);
    exp_t x;
    x.cyc = at; x.w4 = 1'b1; x.tag = tag; x.code = code; x.state = st;
    x.chg = chg; x.cf = 1'b0; x.dw = '0; x.to = 1'b0;
    sb.push_back(x);
  endtask
  task automatic step(logic [2:0] s, logic [2:0] r, logic h);
    @(negedge clk);
    #1;
    i3.set = s; i3.rst = r; i3.hold = h;
    now = cyc;
  endtask
  task automatic step4(logic [3:0] s, logic [3:0] r);
    @(negedge clk);
    #1;
    i4.set = s; i4.rst = r;
    now = cyc;
  endtask
  task automatic idle_until(int n);
    while (now < n) step(3'b000, 3'b000, 1'b0);
  endtask
  initial begin
    int c, x, h, p, q;
    porb = 1'b0;
    i3.set = '0; i3.rst = '0; i3.hold = 1'b0;
    i4.set = '0; i4.rst = '0; i4.hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e3(cyc, "reset", 3'd0, 8'h01, 0, 0, 8'd0, 0);
    @(negedge clk);
    #1;
    porb = 1'b1;
    // single set pulse, then dwell counting
    step(3'b001, 3'b000, 1'b0); c = now;
    e3(c + 2, "set1", 3'd1, 8'h02, 1, 0, 8'd0, 0);
    e3(c + 3, "set1 d1", 3'd1, 8'h02, 0, 0, 8'd1, 0);
    e3(c + 4, "set1 d2", 3'd1, 8'h02, 0, 0, 8'd2, 0);
    e3(c + 5, "set1 d3", 3'd1, 8'h02, 0, 0, 8'd3, 0);
    step(3'b000, 3'b000, 1'b0);
    idle_until(c + 5);
    // 001 -> 011, then set and reset on different bits together -> 110
    step(3'b010, 3'b000, 1'b0); c = now;
    e3(c + 2, "to011", 3'd3, 8'h08, 1, 0, 8'd0, 0);
    step(3'b000, 3'b000, 1'b0);
    step(3'b100, 3'b001, 1'b0); c = now;
    e3(c + 2, "multi", 3'd6, 8'h40, 1, 0, 8'd0, 0);
    e3(c + 3, "multi after", 3'd6, 8'h40, 0, 0, 8'd1, 0);
    step(3'b000, 3'b000, 1'b0);
    // 110 -> 010, then same-bit set+reset: reset wins with conflict strobe
    step(3'b000, 3'b100, 1'b0); c = now;
    e3(c + 2, "to010", 3'd2, 8'h04, 1, 0, 8'd0, 0);
    step(3'b000, 3'b000, 1'b0);
    step(3'b010, 3'b010, 1'b0); c = now;
    e3(c + 2, "conflict", 3'd0, 8'h01, 1, 1, 8'd0, 0);
    e3(c + 3, "conflict after", 3'd0, 8'h01, 0, 0, 8'd1, 0);
    step(3'b000, 3'b000, 1'b0);
    // long idle: timeout at 200, dwell saturates at 255
    x = c + 2;
    e3(x + 199, "dw199", 3'd0, 8'h01, 0, 0, 8'd199, 0);
    e3(x + 200, "dw200", 3'd0, 8'h01, 0, 0, 8'd200, 1);
    e3(x + 255, "dw255", 3'd0, 8'h01, 0, 0, 8'd255, 1);
    e3(x + 261, "dw sat", 3'd0, 8'h01, 0, 0, 8'd255, 1);
    idle_until(x + 259);
    step(3'b100, 3'b000, 1'b0); h = now;
    e3(h + 2, "tmo clear", 3'd4, 8'h10, 1, 0, 8'd0, 0);
    e3(h + 3, "tmo after", 3'd4, 8'h10, 0, 0, 8'd1, 0);
    step(3'b000, 3'b000, 1'b0);
    // hold blocks requests and conflict; porb then drops a request in flight
    step(3'b111, 3'b001, 1'b1); p = now;
    e3(p + 2, "hold a", 3'd4, 8'h10, 0, 0, 8'd2, 0);
    e3(p + 3, "hold b", 3'd4, 8'h10, 0, 0, 8'd3, 0);
    step(3'b111, 3'b001, 1'b1);
    step(3'b111, 3'b001, 1'b1);
    step(3'b011, 3'b000, 1'b0);
    @(posedge clk);
    #2;
    porb = 1'b0;
    i3.set = '0; i3.rst = '0;
    e3(cyc, "porb async", 3'd0, 8'h01, 0, 0, 8'd0, 0);
    @(negedge clk);
    e3(cyc + 1, "porb low", 3'd0, 8'h01, 0, 0, 8'd0, 0);
    @(negedge clk);
    #1;
    porb = 1'b1;
    e3(cyc + 1, "post rst a", 3'd0, 8'h01, 0, 0, 8'd1, 0);
    e3(cyc + 2, "post rst b", 3'd0, 8'h01, 0, 0, 8'd2, 0);
    now = cyc;
    // WIDTH=4: direct code, then walk all 16 codes on consecutive cycles
    step4(4'b1010, 4'b0000); q = now;
    e4(q + 2, "w4 A", 4'hA, 16'h0400, 1);
    for (int k = 0; k < 16; k++) begin
      step4(4'(k), ~4'(k));
      e4(now + 2, $sformatf("w4 walk%0d", k), 4'(k), 16'h0001 << k, 1);
    end
    step4(4'b0000, 4'b0000);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
